// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: index-width helper, default port counts and the master index type.
package xbar_pkg;

    // Width of an index into n items; never zero so single-item configs still get a 1-bit field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int XBAR_MASTERS = 2;
    localparam int XBAR_SLAVES  = 2;

    localparam int MASTER_IDX_W = idx_width(XBAR_MASTERS);
    localparam int DEST_SLAVE_W = idx_width(XBAR_SLAVES);

    typedef logic [MASTER_IDX_W-1:0] master_idx_t;

endpackage

// File: rtl/xbar_order_queue.sv
// In-order FIFO of master indices recording which master owns each outstanding write burst.
// The front output holds the last valid head while the queue is empty.
module xbar_order_queue
    import xbar_pkg::*;
#(
    parameter int width = MASTER_IDX_W,
    parameter int depth = 4
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] front
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    logic [width-1:0] mem_reg [depth];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [width-1:0] last_front_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(depth));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign front   = empty ? last_front_reg : mem_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            last_front_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (!empty)
                last_front_reg <= mem_reg[rd_ptr_reg];
        end
    end

    // Storage carries no reset; a slot is only read after it has been written.
    always_ff @(posedge ACLK) begin
        if (push_ok)
            mem_reg[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/xbar_slave_write_scheduler.sv
// Per-slave write scheduler: arbitrates master AWs into this slave and steers W beats in AW order.
// Define XBAR_WRITE_SCHED_FIXED_PRIO_EN for fixed-priority (lowest index) AW arbitration.
module xbar_slave_write_scheduler
    import xbar_pkg::*;
#(
    parameter int masters           = XBAR_MASTERS,
    parameter int slaves            = XBAR_SLAVES,
    parameter int i_am_slave_number = 0,
    parameter int order_depth       = 4
) (
    input  logic                                      ACLK,
    input  logic                                      ARESETn,
    input  logic [masters-1:0]                        master_write_addr_fifo_empty,
    input  logic [masters-1:0][idx_width(slaves)-1:0] write_addr_forward_dest_slave,
    input  logic [masters-1:0]                        master_write_data_fifo_empty,
    input  logic [masters-1:0]                        master_wlast,
    input  logic                                      slave_write_addr_fifo_full,
    input  logic                                      slave_write_data_fifo_full,
    output logic                                      aw_grant_valid,
    output logic [idx_width(masters)-1:0]             aw_grant_master,
    output logic                                      w_grant_valid,
    output logic [idx_width(masters)-1:0]             w_grant_master,
    output logic                                      order_queue_full,
    output logic                                      order_queue_empty
);

    localparam int MIDX_W = idx_width(masters);
    localparam int DEST_W = idx_width(slaves);

    logic [masters-1:0] aw_req;
    logic [MIDX_W-1:0]  grant_idx;
    logic [MIDX_W-1:0]  w_head;
    logic               w_pop;

    for (genvar gi = 0; gi < masters; gi++) begin : g_req
        assign aw_req[gi] = ~master_write_addr_fifo_empty[gi] &
                            (write_addr_forward_dest_slave[gi] == DEST_W'(i_am_slave_number));
    end

`ifdef XBAR_WRITE_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant_idx = '0;
        for (int i = masters - 1; i >= 0; i--) begin
            if (aw_req[i])
                grant_idx = MIDX_W'(i);
        end
    end
`else
    logic [MIDX_W-1:0] rr_reg;

    // First requester at or after the pointer wins, wrapping modulo masters.
    always_comb begin
        logic found;
        int   idx;
        found     = 1'b0;
        idx       = 0;
        grant_idx = '0;
        for (int i = 0; i < masters; i++) begin
            idx = (int'(rr_reg) + i) % masters;
            if (!found && aw_req[idx]) begin
                found     = 1'b1;
                grant_idx = MIDX_W'(idx);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            rr_reg <= '0;
        else if (aw_grant_valid)
            rr_reg <= (grant_idx == MIDX_W'(masters - 1)) ? '0 : grant_idx + MIDX_W'(1);
    end
`endif

    // Full is taken from the registered count, so a same-cycle pop never frees a slot for this AW.
    assign aw_grant_valid  = (|aw_req) & ~slave_write_addr_fifo_full & ~order_queue_full;
    assign aw_grant_master = grant_idx;

    xbar_order_queue #(
        .width (MIDX_W),
        .depth (order_depth)
    ) u_order_queue (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .push      (aw_grant_valid),
        .push_data (grant_idx),
        .pop       (w_pop),
        .full      (order_queue_full),
        .empty     (order_queue_empty),
        .front     (w_head)
    );

    assign w_grant_master = w_head;
    assign w_grant_valid  = ~order_queue_empty & ~master_write_data_fifo_empty[w_head] &
                            ~slave_write_data_fifo_full;
    assign w_pop          = w_grant_valid & master_wlast[w_head];

endmodule

// File: doc/xbar_slave_write_scheduler.md
Name: xbar_slave_write_scheduler

Overview:
- Slave-side write-path scheduler, one instance per slave port of the crossbar.
- Round-robin arbitrates which master's AW FIFO head is forwarded into this slave's AW FIFO.
- Records each granted master in an in-order W-ownership queue, then steers W beats from the queue-head master only, until a beat with WLAST is forwarded.
- Guarantees W data reaches the slave in AW order, with no interleaving between masters.

Parameters:
- masters, 2, number of master interfaces.
- slaves, 2, number of slave ports; sets the destination-field width.
- i_am_slave_number, 0, index of this slave port; used to match destination fields.
- order_depth, 4, W-ownership queue depth (power of 2, >=2); maximum accepted AWs whose W bursts are not yet complete.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- master_write_addr_fifo_empty  in  [masters]  per-master AW FIFO empty (already gated by that master's W-busy flag)
- write_addr_forward_dest_slave  in  [masters][$clog2(slaves)]  decoded AW destination per master
- master_write_data_fifo_empty  in  [masters]  per-master W FIFO empty (gated)
- master_wlast  in  [masters]  WLAST of each master's W FIFO head
- slave_write_addr_fifo_full  in  1  this slave's AW FIFO full
- slave_write_data_fifo_full  in  1  this slave's W FIFO full
- aw_grant_valid  out  1  AW transfer from aw_grant_master this cycle
- aw_grant_master  out  $clog2(masters)  AW mux select
- w_grant_valid  out  1  W beat transfer from w_grant_master this cycle
- w_grant_master  out  $clog2(masters)  W mux select (queue head)
- order_queue_full  out  1  status
- order_queue_empty  out  1  status

Behaviour:
- Reset (synchronous, ARESETn=0 at ACLK edge):
  - RR pointer = 0; queue read/write pointers = 0; count = 0.
  - Outputs: aw_grant_valid=0, w_grant_valid=0, order_queue_empty=1, order_queue_full=0.
  - aw_grant_master=0, w_grant_master=0.
- AW request from master m: ~master_write_addr_fifo_empty[m] & (write_addr_forward_dest_slave[m]==i_am_slave_number).
- AW grant (combinational):
  - Search starts at the RR pointer, wrapping modulo masters; first requester wins and drives aw_grant_master.
  - aw_grant_valid = any request & ~slave_write_addr_fifo_full & ~order_queue_full.
  - A full queue blocks AW even if the queue pops in the same cycle (no same-cycle full bypass).
- On aw_grant_valid:
  - RR pointer <= (granted+1) mod masters.
  - Granted index is written at the write pointer; count increments.
- W steering:
  - w_grant_master = entry at the read pointer; it holds its value while the queue is empty.
  - w_grant_valid = ~order_queue_empty & ~master_write_data_fifo_empty[head] & ~slave_write_data_fifo_full.
- On w_grant_valid & master_wlast[head]: read pointer advances and count decrements. Non-last beats leave the queue unchanged.
- Latency: an AW grant in cycle N makes its master the W owner in cycle N+1 at the earliest. There is no empty-queue bypass.
- Simultaneous push and last-beat pop: count is unchanged and both pointers advance. This is legal whenever the queue is not full.
- Pointers are $clog2(order_depth) bits and wrap naturally. Count is $clog2(order_depth)+1 bits.
- Masters with pending W to other slaves never assert requests here; W of other owners is ignored.
- Reset mid-burst: queue contents are discarded. The whole crossbar resets together, so no recovery is required.
- masters==1: RR logic degenerates; grant is always master 0.

Optional Feature:
- Macro: XBAR_WRITE_SCHED_FIXED_PRIO_EN.
- Defined: AW arbitration is fixed priority, lowest master index wins, and the RR pointer is not instantiated.
- Undefined: round-robin as specified above.
- The W ordering queue is identical in both builds.

Decomposition:
- Shared package xbar_pkg: the master-index width function/localparam, the dest-slave width localparam, and a master_idx_t typedef.
- One natural sub-module, xbar_order_queue: a parameterised synchronous FIFO of master indices with push, pop, full, empty and front.
- The scheduler keeps arbitration and steering logic.

Test Plan:
- Masters 0 and 1 both request slave 0 continuously, each with a 1-beat W → AW grants alternate 0,1,0,1; w_grant_master follows the same order, one cycle behind.
- Master 1 issues AW with a 4-beat W, then master 0 issues AW → W beats come only from master 1 until WLAST; w_grant_master switches to 0 the cycle after.
- order_depth=4, six AWs granted while all W FIFOs are empty → order_queue_full=1 after 4; aw_grant_valid held 0 until the first WLAST pop.
- Queue full and a WLAST pop in the same cycle with a pending AW → no AW grant that cycle; granted the next cycle, count stays 4.
- slave_write_data_fifo_full=1 during a burst → w_grant_valid=0 and queue unchanged; resumes at the same beat when it drops.
- ARESETn=0 while the queue holds 2 entries → next cycle order_queue_empty=1, both grants 0, RR pointer 0.
